uart_tx_arbiter: RTL and testbench

- Shares one byte-serial `transmit` datapath among N_REQ independent byte producers.
- Per requester: a valid/ready byte handshake; arbitration is round-robin.
- Sequences the transmitter's start/busy handshake and enforces an inter-frame gap.
- Gates new grants on `connection_status` and detects a transmitter that never starts.

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one byte-serial transmitter from N_REQ producers,
// sequencing its start/busy handshake, an inter-frame gap and a start timeout.
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     connection_status,
  input  logic                     tx_busy,
  output logic [7:0]               tx_word,
  output logic                     tx_start,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active,
  output logic                     err_timeout,
  output logic [7:0]               err_count
);

  localparam int IDW = $clog2(N_REQ);
  localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW  = $clog2(START_TIMEOUT);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [GW-1:0]  gap_cnt;
  logic [TW-1:0]  tmo_cnt;

  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx_w;
  logic [7:0]     sel_byte;
  logic           grant_req;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Search upward from the slot after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    winner = '0;
    idx_w = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx_w = IDW'((int'(last_grant) + off) % N_REQ);
      if (!found && req_valid[idx_w]) begin
        found = 1'b1;
        winner = idx_w;
      end
    end
  end

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == winner) sel_byte = req_data[i*8 +: 8];
    end
  end

  assign grant_req = (state == IDLE) && connection_status && found;
  assign req_ready = grant_req ? (N_REQ'(1) << winner) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= IDW'(N_REQ - 1);
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      tx_word     <= '0;
      tx_start    <= 1'b0;
      grant_id    <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_req) begin
            tx_word    <= sel_byte;
            grant_id   <= winner;
            last_grant <= winner;
            tx_start   <= 1'b1;
            active     <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // Timeout fires on the edge where the count would reach START_TIMEOUT-1.
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == TW'(START_TIMEOUT - 2)) begin
            err_timeout <= 1'b1;
            err_count   <= sat_inc(err_count);
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (GAP_CYCLES == 0) begin
              active <= 1'b0;
              state  <= IDLE;
            end else begin
              gap_cnt <= GW'(GAP_CYCLES);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(1)) begin
            active <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table of grants plus
// hand-written sequences for link, timeout and reset corner cases.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        connection_status;
  logic        tx_busy;
  logic [7:0]  tx_word;
  logic        tx_start;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(2), .START_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .connection_status(connection_status),
    .tx_busy(tx_busy), .tx_word(tx_word), .tx_start(tx_start),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [1:0] id;
    logic [7:0] word;
    int         blen;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tx_busy = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One full frame: request, grant, busy for blen clocks, then wait for idle.
  task automatic do_txn(input logic [3:0] valid, input logic [1:0] exp_id,
                        input logic [7:0] exp_word, input int blen);
    int n;
    int stray;
    req_valid = valid;
    connection_status = 1'b1;
    #1;
    check("ready_onehot", 32'(req_ready), 32'(4'b0001 << exp_id));
    step();
    req_valid = '0;
    check("tx_start_pulse", 32'(tx_start), 32'd1);
    check("tx_word", 32'(tx_word), 32'(exp_word));
    check("grant_id", 32'(grant_id), 32'(exp_id));
    check("active_hi", 32'(active), 32'd1);
    check("ready_busy", 32'(req_ready), 32'd0);
    step();
    tx_busy = 1'b1;
    stray = 0;
    for (int i = 0; i < blen; i++) begin
      if (tx_start) stray++;
      step();
    end
    tx_busy = 1'b0;
    n = 0;
    while (active && n < 50) begin
      if (tx_start) stray++;
      if (tx_word !== exp_word) stray++;
      step();
      n++;
    end
    check("single_start_stable_word", 32'(stray), 32'd0);
    // WAIT_DONE samples busy low, then two GAP clocks.
    check("active_fall", 32'(n), 32'd3);
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    connection_status = 1'b0;
    tx_busy = 1'b0;
    #2;
    check("rst_tx_word", 32'(tx_word), 32'd0);
    check("rst_outputs", {tx_start, active, err_timeout, 6'b0, grant_id}, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    step();
    step();
    rst = 1'b0;

    // Single byte
    req_data = 32'h0000_0081;
    do_txn(4'b0001, 2'd0, 8'h81, 20);

    // Round-robin and priority table, starting from reset priority.
    do_reset();
    req_data = 32'h4030_2010;
    vecs[0]  = '{4'b1111, 2'd0, 8'h10, 3};
    vecs[1]  = '{4'b1111, 2'd1, 8'h20, 1};
    vecs[2]  = '{4'b1111, 2'd2, 8'h30, 5};
    vecs[3]  = '{4'b1111, 2'd3, 8'h40, 2};
    vecs[4]  = '{4'b1111, 2'd0, 8'h10, 3};
    vecs[5]  = '{4'b1000, 2'd3, 8'h40, 2};
    vecs[6]  = '{4'b1001, 2'd0, 8'h10, 2};
    vecs[7]  = '{4'b0110, 2'd1, 8'h20, 4};
    vecs[8]  = '{4'b0101, 2'd2, 8'h30, 2};
    vecs[9]  = '{4'b0011, 2'd0, 8'h10, 1};
    vecs[10] = '{4'b0010, 2'd1, 8'h20, 2};
    for (int v = 0; v < 11; v++) do_txn(vecs[v].valid, vecs[v].id, vecs[v].word, vecs[v].blen);

    // Link down blocks grants.
    connection_status = 1'b0;
    req_valid = 4'b0100;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready !== 4'b0000 || tx_start !== 1'b0) bad++;
      step();
    end
    check("linkdown_quiet", 32'(bad), 32'd0);
    do_txn(4'b0100, 2'd2, 8'h30, 4);

    // Start timeout, then saturation.
    connection_status = 1'b1;
    req_valid = 4'b0001;
    #1;
    step();
    check("tmo_start", 32'(tx_start), 32'd1);
    n = 0;
    while (!err_timeout && n < 40) begin
      step();
      n++;
    end
    check("tmo_latency", 32'(n), 32'd16);
    check("tmo_count1", 32'(err_count), 32'd1);
    check("tmo_idle", 32'(active), 32'd0);
    bad = 0;
    for (int r = 0; r < 299; r++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!err_timeout && n < 40);
      if (!err_timeout) bad++;
    end
    check("tmo_repeat_bound", 32'(bad), 32'd0);
    check("tmo_saturate", 32'(err_count), 32'd255);
    req_valid = '0;
    step();
    step();

    // Link drop mid-frame: frame completes, no grant while low.
    req_valid = 4'b0001;
    #1;
    step();
    req_valid = 4'b1111;
    step();
    tx_busy = 1'b1;
    step();
    connection_status = 1'b0;
    for (int i = 0; i < 5; i++) step();
    tx_busy = 1'b0;
    n = 0;
    while (active && n < 50) begin
      step();
      n++;
    end
    check("drop_frame_done", 32'(n), 32'd3);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_ready !== 4'b0000 || tx_start !== 1'b0 || active !== 1'b0) bad++;
      step();
    end
    check("drop_no_grant", 32'(bad), 32'd0);
    connection_status = 1'b1;
    #1;
    check("drop_regrant", 32'(req_ready), 32'b0010);

    // Reset during WAIT_DONE.
    step();
    req_valid = '0;
    check("pre_rst_id", 32'(grant_id), 32'd1);
    step();
    tx_busy = 1'b1;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_word", 32'(tx_word), 32'd0);
    check("async_rst_ctrl", {tx_start, active, err_timeout, 6'b0, grant_id}, 32'd0);
    check("async_rst_errcnt", 32'(err_count), 32'd0);
    tx_busy = 1'b0;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("post_rst_prio", 32'(req_ready), 32'b0001);
    step();
    check("post_rst_word", 32'(tx_word), 32'h10);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
